// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: DATA_W data bits (LSB first) plus an odd-parity bit.
// Each checked word is presented on a valid/ready output. Frame, error and overrun status are kept alongside.
module parity_frame_receiver #(
  parameter int DATA_W  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_parity_ok,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_frame_count,
  output logic [CNT_W-1:0]  o_err_count,
  output logic              o_overrun
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_HOLD} state_t;

  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [TMO_W-1:0]   r_tmo;
  logic [DATA_W-1:0]  r_data;
  logic               r_ok;
  logic [CNT_W-1:0]   r_frame_cnt, r_err_cnt;
  logic               r_overrun;

  logic w_in_frame, w_last_data, w_timeout, w_par, w_hs, w_load;
  logic w_frame_inc, w_err_inc;

  assign w_in_frame  = (r_state == S_DATA) || (r_state == S_PARITY);
  assign w_last_data = (r_idx == IDX_W'(DATA_W - 1));
  // Abort on the edge where the idle-cycle count would reach TIMEOUT.
  assign w_timeout   = w_in_frame && !i_bit_valid && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_par       = (^r_data) ^ i_bit_in;
  assign w_hs        = (r_state == S_HOLD) && i_out_ready;
  assign w_load      = ((r_state == S_IDLE) && i_start) || (w_hs && i_start);
  assign w_frame_inc = (r_state == S_PARITY) && i_bit_valid;
  assign w_err_inc   = (w_frame_inc && !w_par) || w_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_DATA;
      S_DATA:   if (w_timeout) w_next = S_IDLE;
                else if (i_bit_valid && w_last_data) w_next = S_PARITY;
      S_PARITY: if (w_timeout) w_next = S_IDLE;
                else if (i_bit_valid) w_next = S_HOLD;
      S_HOLD:   if (i_out_ready) w_next = i_start ? S_DATA : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_tmo       <= '0;
      r_data      <= '0;
      r_ok        <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= '0;
        r_idx  <= '0;
      end else if ((r_state == S_DATA) && i_bit_valid) begin
        r_data[r_idx] <= i_bit_in;
        r_idx         <= r_idx + 1'b1;
      end
      r_tmo <= (w_in_frame && !i_bit_valid && !w_timeout) ? r_tmo + 1'b1 : '0;
      if (w_frame_inc) r_ok <= w_par;
      // Counters hold at all-ones instead of wrapping.
      if (w_frame_inc && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_err_inc && (r_err_cnt != '1))     r_err_cnt   <= r_err_cnt + 1'b1;
      if ((r_state == S_HOLD) && i_bit_valid) r_overrun <= 1'b1;
    end
  end

  assign o_out_valid     = (r_state == S_HOLD);
  assign o_out_data      = r_data;
  assign o_out_parity_ok = r_ok;
  assign o_busy          = (r_state != S_IDLE);
  assign o_frame_count   = r_frame_cnt;
  assign o_err_count     = r_err_cnt;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Self-checking bench for parity_frame_receiver: directed scenarios plus randomized
// frames compared against a count-of-ones parity model with saturating counters.
module tb_parity_frame_receiver;
  localparam int DW = 5;
  localparam int CW = 8;
  localparam int TO = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bit_in, bit_valid, out_ready;
  logic out_valid, ok, busy, ovr;
  logic [DW-1:0] out_data;
  logic [CW-1:0] fc, ec;

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc, exp_ec;

  parity_frame_receiver #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_bit_in(bit_in),
    .i_bit_valid(bit_valid), .i_out_ready(out_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_parity_ok(ok),
    .o_busy(busy), .o_frame_count(fc), .o_err_count(ec), .o_overrun(ovr));

  function automatic logic [CW-1:0] sat(input int v);
    return (v >= CMAX) ? CW'(CMAX) : CW'(v);
  endfunction

  function automatic logic odd_ok(input logic [DW-1:0] d, input logic p);
    return ($countones({d, p}) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_fc = 0; exp_ec = 0;
  endtask

  // Drive data bits then parity, with up to maxgap idle cycles before each bit.
  task automatic send_bits(input logic [DW-1:0] d, input logic p, input int maxgap);
    for (int i = 0; i <= DW; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      bit_valid = 1'b1;
      bit_in = (i == DW) ? p : d[i];
      tick();
      bit_valid = 1'b0; bit_in = 1'b0;
    end
    exp_fc++;
    if (!odd_ok(d, p)) exp_ec++;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input int maxgap);
    start = 1'b1; tick(); start = 1'b0;
    send_bits(d, p, maxgap);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, out_data, ok, busy, fc, ec, ovr} !== '0) begin
      n_err++;
      $display("FAIL reset: got v=%b d=%b ok=%b busy=%b fc=%0d ec=%0d ovr=%b, want all 0",
               out_valid, out_data, ok, busy, fc, ec, ovr);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] d;
    d = 5'b10110;
    send_frame(d, 1'b0, 0);
    n_cmp++;
    if ({out_valid, out_data, ok, fc, ec} !== {1'b1, 5'b10110, 1'b1, 8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL dir_ok: got v=%b d=%b ok=%b fc=%0d ec=%0d, want v=1 d=10110 ok=1 fc=1 ec=0",
               out_valid, out_data, ok, fc, ec);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++;
    if ({busy, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL dir_release: got busy=%b v=%b, want 0 0", busy, out_valid);
    end
    send_frame(d, 1'b1, 1);
    n_cmp++;
    if ({out_valid, out_data, ok, fc, ec} !== {1'b1, 5'b10110, 1'b0, 8'd2, 8'd1}) begin
      n_err++;
      $display("FAIL dir_bad: got v=%b d=%b ok=%b fc=%0d ec=%0d, want v=1 d=10110 ok=0 fc=2 ec=1",
               out_valid, out_data, ok, fc, ec);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    d = '0;
    send_frame(d, 1'b1, 0);
    n_cmp++;
    if ({out_valid, out_data, ok, fc, ec} !== {1'b1, 5'b00000, 1'b1, 8'd3, 8'd1}) begin
      n_err++;
      $display("FAIL dir_zero: got v=%b d=%b ok=%b fc=%0d ec=%0d, want v=1 d=00000 ok=1 fc=3 ec=1",
               out_valid, out_data, ok, fc, ec);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [DW-1:0] d;
    logic p;
    d = DW'($urandom); p = 1'($urandom);
    send_frame(d, p, 2);
    for (int c = 0; c < 10; c++) begin
      if (c == 5) bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_data, ok} !== {1'b1, d, odd_ok(d, p)}) begin
        n_err++;
        $display("FAIL hold_stable c=%0d: got v=%b d=%b ok=%b, want v=1 d=%b ok=%b",
                 c, out_valid, out_data, ok, d, odd_ok(d, p));
      end
    end
    n_cmp++;
    if ({ovr, fc, ec} !== {1'b1, sat(exp_fc), sat(exp_ec)}) begin
      n_err++;
      $display("FAIL hold_overrun: got ovr=%b fc=%0d ec=%0d, want ovr=1 fc=%0d ec=%0d",
               ovr, fc, ec, sat(exp_fc), sat(exp_ec));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++;
    if ({busy, out_valid, ovr} !== 3'b001) begin
      n_err++;
      $display("FAIL hold_release: got busy=%b v=%b ovr=%b, want 0 0 1", busy, out_valid, ovr);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2;
    do_reset();
    d1 = DW'($urandom); d2 = DW'($urandom);
    send_frame(d1, 1'b1, 0);
    out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    n_cmp++;
    if ({busy, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_data: got busy=%b v=%b, want 1 0", busy, out_valid);
    end
    send_bits(d2, 1'b0, 0);
    n_cmp++;
    if ({out_valid, out_data, ok, fc, ec} !== {1'b1, d2, odd_ok(d2, 1'b0), 8'd2, sat(exp_ec)}) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b d=%b ok=%b fc=%0d ec=%0d, want v=1 d=%b ok=%b fc=2 ec=%0d",
               out_valid, out_data, ok, fc, ec, d2, odd_ok(d2, 1'b0), sat(exp_ec));
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic p, b2b;
    do_reset();
    b2b = 1'b0;
    for (int n = 0; n < 40; n++) begin
      d = DW'($urandom); p = 1'($urandom);
      if (b2b) send_bits(d, p, 4);
      else     send_frame(d, p, 4);
      repeat ($urandom_range(3, 0)) tick();
      n_cmp++;
      if ({out_valid, out_data, ok, fc, ec} !== {1'b1, d, odd_ok(d, p), sat(exp_fc), sat(exp_ec)}) begin
        n_err++;
        $display("FAIL rand n=%0d: got v=%b d=%b ok=%b fc=%0d ec=%0d, want v=1 d=%b ok=%b fc=%0d ec=%0d",
                 n, out_valid, out_data, ok, fc, ec, d, odd_ok(d, p), sat(exp_fc), sat(exp_ec));
      end
      b2b = 1'($urandom);
      start = b2b; out_ready = 1'b1; tick(); start = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if ({busy, out_valid} !== {b2b, 1'b0}) begin
        n_err++;
        $display("FAIL rand_hs n=%0d: got busy=%b v=%b, want busy=%b v=0", n, busy, out_valid, b2b);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom); tick();
    end
    bit_valid = 1'b0;
    repeat (TO - 1) tick();
    n_cmp++;
    if ({busy, out_valid, ec} !== {1'b1, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL tmo_early: got busy=%b v=%b ec=%0d, want busy=1 v=0 ec=0", busy, out_valid, ec);
    end
    tick();
    n_cmp++;
    if ({busy, out_valid, fc, ec} !== {1'b0, 1'b0, 8'd0, 8'd1}) begin
      n_err++;
      $display("FAIL tmo_abort: got busy=%b v=%b fc=%0d ec=%0d, want busy=0 v=0 fc=0 ec=1",
               busy, out_valid, fc, ec);
    end
    // Leave a held word and sticky overrun, restart back-to-back, then reset mid-frame.
    send_frame(5'b11111, 1'b0, 0);
    bit_valid = 1'b1; tick(); bit_valid = 1'b0;
    out_ready = 1'b1; start = 1'b1; tick(); out_ready = 1'b0; start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1; tick(); tick(); bit_valid = 1'b0; bit_in = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_data, ok, busy, fc, ec, ovr} !== '0) begin
      n_err++;
      $display("FAIL mid_rst: got v=%b d=%b ok=%b busy=%b fc=%0d ec=%0d ovr=%b, want all 0",
               out_valid, out_data, ok, busy, fc, ec, ovr);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d;
    do_reset();
    for (int n = 0; n < 260; n++) begin
      d = DW'($urandom);
      send_frame(d, ^d, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      if (n == CMAX - 2) begin
        n_cmp++;
        if ({fc, ec} !== {CW'(CMAX - 1), CW'(CMAX - 1)}) begin
          n_err++;
          $display("FAIL sat_pre: got fc=%0d ec=%0d, want %0d %0d", fc, ec, CMAX - 1, CMAX - 1);
        end
      end
    end
    n_cmp++;
    if ({fc, ec} !== {sat(exp_fc), sat(exp_ec)}) begin
      n_err++;
      $display("FAIL sat_frames: got fc=%0d ec=%0d, want %0d %0d", fc, ec, sat(exp_fc), sat(exp_ec));
    end
    start = 1'b1; tick(); start = 1'b0;
    repeat (TO) tick();
    exp_ec++;
    n_cmp++;
    if ({busy, fc, ec} !== {1'b0, sat(exp_fc), sat(exp_ec)}) begin
      n_err++;
      $display("FAIL sat_tmo: got busy=%b fc=%0d ec=%0d, want busy=0 fc=%0d ec=%0d",
               busy, fc, ec, sat(exp_fc), sat(exp_ec));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
